tlb_op_ctrl: RTL
================

Name: tlb_op_ctrl

Overview:
- Sequences MIPS TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR) issued by the MEM stage against the shared instruction/data/probe TLB.
- Generates single-cycle write strobes toward the TLB.
- Maintains the CP0 Random register.
- Registers the probe and read results and writes them back to CP0 Index / EntryHi-Lo.
- Stalls the pipeline until the operation commits.

Parameters:
- TLB_ENTRIES, 16, number of TLB entries; index width is clog2(TLB_ENTRIES) = 4.
- CONF_W, 86, width of one packed TLB entry (VPN2/ASID/G/PFN0/PFN1/flags), matching the CP0 configuration bus.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  TLB instruction present in MEM
- op_type  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready  out  1  controller idle; accepts op this cycle
- op_done  out  1  one-cycle pulse when op commits
- stall  out  1  hold pipeline
- flush  in  1  exception/ERET flush
- cp0_index_in  in  4  current CP0 Index[3:0]
- wired_we  in  1  CP0 Wired write
- wired_wdata  in  4  new Wired value
- random  out  4  CP0 Random value, also drives TLB cp0_random
- tlb_index  out  4  index presented to TLB for TLBR/TLBWI
- tlbwi  out  1  TLB write-indexed strobe
- tlbwr  out  1  TLB write-random strobe
- probe_miss  in  1  TLB probe miss
- probe_index  in  4  TLB probe matched index
- entry_in  in  CONF_W  entry read from TLB at tlb_index
- index_we  out  1  CP0 Index write enable
- index_wdata  out  32  {P,27'b0,idx}
- conf_we  out  1  CP0 EntryHi/Lo0/Lo1 write enable
- conf_wdata  out  CONF_W  entry data for CP0

Behaviour:
- Reset: FSM IDLE; random = 15; wired = 0; all strobes/we = 0; stall = 0; op_done = 0; op_ready = 1; data outputs 0.
- Accept when op_valid && op_ready && !flush. Op type and operand index latch at accept:
  - cp0_index_in for TLBR/TLBWI.
  - Current random for TLBWR.
- stall = op_valid && (FSM != IDLE || accept) && !op_done.
- States: IDLE, PROBE_WAIT, READ_WAIT, WRITE, DRAIN.
- TLBP: IDLE -> PROBE_WAIT (cycle1; probe inputs registered at end) -> writeback in cycle2.
  - index_we = 1; index_wdata = {probe_miss, 27'b0, probe_miss ? 4'b0 : probe_index}.
  - op_done = 1; -> IDLE.
- TLBR: IDLE -> READ_WAIT (cycle1; tlb_index = latched index; entry_in registered) -> cycle2.
  - conf_we = 1; conf_wdata = registered entry; op_done = 1; -> IDLE.
- TLBWI/TLBWR: IDLE -> WRITE (cycle1).
  - Exactly one of tlbwi/tlbwr pulses high.
  - tlb_index = latched index (TLBWR: latched random, also driven on random during this cycle).
  - -> DRAIN (cycle2; lets TLB lookups see the new entry) -> op_done, -> IDLE.
- Latency: every op is accepted at cycle 0 and reaches op_done at cycle 2. Back-to-back ops: next op is accepted in the cycle after op_done.
- Flush:
  - flush in PROBE_WAIT, READ_WAIT or WRITE: abort. No index_we, conf_we, tlbwi or tlbwr that cycle or later; no op_done; -> IDLE next cycle.
  - flush in DRAIN: ignored; the write has committed and op_done still fires.
  - flush in IDLE blocks acceptance.
- Random:
  - Decrements every cycle except the WRITE cycle of TLBWR, where it holds.
  - When random == wired, next value = 15 (wrap).
  - wired_we: wired <= wired_wdata and random <= 15, with priority over decrement.
  - wired = 15 keeps random at 15.
  - If wired > random ever occurs, next value = 15.
- Simultaneous wired_we and TLBWR accept: latched random is the pre-update value.
- rst mid-operation: all state returns to reset values next cycle; pending writes are dropped.

Optional Feature:
- Macro: TLB_OP_PERF_CNT_EN.
- Defined: adds outputs perf_probe_miss_cnt[31:0] and perf_tlbw_cnt[31:0].
  - perf_probe_miss_cnt increments on each committed TLBP with P = 1.
  - perf_tlbw_cnt increments on each committed TLBWI/TLBWR (at DRAIN commit, after the DRAIN-cycle flush has been ignored; flush in WRITE aborts so no count).
  - Both wrap at 2^32; both reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package tlb_pkg holds:
  - tlb_op_t enum (TLBP/TLBR/TLBWI/TLBWR).
  - tlb_op_state_t enum.
  - CONF_W and INDEX_W constants.
  - INDEX_P_BIT = 31.
- Sub-module tlb_random_gen: Wired register plus Random down-counter with wrap, hold and reload inputs.

Test Plan:
- TLBP with probe_miss = 0, probe_index = 9 -> index_we at cycle2, index_wdata = 0x00000009, op_done at cycle2, stall high cycles 0-1.
- TLBP with probe_miss = 1 -> index_wdata = 0x80000000.
- TLBR with cp0_index_in = 5, entry_in = pattern A -> tlb_index = 5 in cycle1; conf_we with conf_wdata = A at cycle2.
- wired_wdata = 12, then idle 5 cycles -> random sequence 15, 14, 13, 12, 15. Then TLBWR accepted while random = 14 -> tlbwr pulse with tlb_index = 14, random holds that cycle.
- TLBWI with flush asserted in WRITE -> no tlbwi, no op_done, op_ready = 1 next cycle.
- TLBWI with flush asserted in DRAIN -> tlbwi already issued and op_done = 1.
- rst asserted in READ_WAIT -> no conf_we; random = 15 and op_ready = 1 the next cycle.

Source files
------------

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and constants for the TLB maintenance sequencer.
//   tlb_op_t       - MEM-stage TLB instruction encoding (TLBP/TLBR/TLBWI/TLBWR)
//   tlb_op_state_t - sequencer FSM states
//   INDEX_W        - TLB index width, CONF_W - packed entry width
//   INDEX_P_BIT    - position of the probe-failure bit in CP0 Index
package tlb_pkg;

  localparam int TLB_ENTRIES = 16;
  localparam int INDEX_W     = $clog2(TLB_ENTRIES);
  localparam int CONF_W      = 86;
  localparam int INDEX_P_BIT = 31;

  localparam logic [INDEX_W-1:0] RANDOM_MAX = INDEX_W'(TLB_ENTRIES - 1);

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_TLBWR = 2'b11
  } tlb_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE_WAIT,
    ST_READ_WAIT,
    ST_WRITE,
    ST_DRAIN
  } tlb_op_state_t;

endpackage

// File: rtl/tlb_random_gen.sv
// tlb_random_gen: CP0 Wired register plus the Random down-counter.
//   clk, rst           - clock, synchronous active-high reset
//   wired_we_i/wdata_i - Wired write; also reloads Random to the top entry
//   hold_i             - freeze Random this cycle (TLBWR write cycle)
//   random_o           - current Random value
// Random counts down and wraps to the top entry once it reaches Wired, so the
// entries below Wired are never chosen. A Random below Wired (possible right
// after Wired grows) also reloads to the top.
module tlb_random_gen
  import tlb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wired_we_i,
  input  logic [INDEX_W-1:0] wired_wdata_i,
  input  logic               hold_i,
  output logic [INDEX_W-1:0] random_o
);

  logic [INDEX_W-1:0] random_q, random_d;
  logic [INDEX_W-1:0] wired_q, wired_d;

  always_comb begin
    wired_d  = wired_q;
    random_d = random_q;
    if (wired_we_i) begin
      wired_d  = wired_wdata_i;
      random_d = RANDOM_MAX;
    end else if (hold_i) begin
      random_d = random_q;
    end else if (random_q <= wired_q) begin
      random_d = RANDOM_MAX;
    end else begin
      random_d = random_q - INDEX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= RANDOM_MAX;
      wired_q  <= '0;
    end else begin
      random_q <= random_d;
      wired_q  <= wired_d;
    end
  end

  assign random_o = random_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP/TLBR/TLBWI/TLBWR from MEM against the shared TLB.
//   op_valid/op_type/op_ready/op_done/stall/flush - pipeline handshake
//   cp0_index_in, wired_we, wired_wdata           - CP0 inputs
//   random, tlb_index, tlbwi, tlbwr               - TLB side (write strobes)
//   probe_miss, probe_index, entry_in             - TLB probe/read results
//   index_we/index_wdata, conf_we/conf_wdata      - CP0 writeback
// Every op: accept (cycle 0) -> work state (cycle 1) -> DRAIN commit (cycle 2).
// Flush aborts in the work state; DRAIN always commits.
// Optional macro TLB_OP_PERF_CNT_EN adds perf_probe_miss_cnt / perf_tlbw_cnt.
module tlb_op_ctrl
  import tlb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [1:0]         op_type,
  output logic               op_ready,
  output logic               op_done,
  output logic               stall,
  input  logic               flush,
  input  logic [INDEX_W-1:0] cp0_index_in,
  input  logic               wired_we,
  input  logic [INDEX_W-1:0] wired_wdata,
  output logic [INDEX_W-1:0] random,
  output logic [INDEX_W-1:0] tlb_index,
  output logic               tlbwi,
  output logic               tlbwr,
  input  logic               probe_miss,
  input  logic [INDEX_W-1:0] probe_index,
  input  logic [CONF_W-1:0]  entry_in,
  output logic               index_we,
  output logic [31:0]        index_wdata,
  output logic               conf_we,
  output logic [CONF_W-1:0]  conf_wdata
`ifdef TLB_OP_PERF_CNT_EN
  ,
  output logic [31:0]        perf_probe_miss_cnt,
  output logic [31:0]        perf_tlbw_cnt
`endif
);

  tlb_op_state_t      state_q, state_d;
  tlb_op_t            op_q, op_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic               pmiss_q, pmiss_d;
  logic [INDEX_W-1:0] pidx_q, pidx_d;
  logic [CONF_W-1:0]  entry_q, entry_d;
  logic [INDEX_W-1:0] rnd;
  logic               rnd_hold;
  logic               accept;

  assign op_ready = (state_q == ST_IDLE);
  assign accept   = op_valid && op_ready && !flush;
  assign stall    = op_valid && (state_q != ST_IDLE || accept) && !op_done;

  tlb_random_gen u_random (
    .clk          (clk),
    .rst          (rst),
    .wired_we_i   (wired_we),
    .wired_wdata_i(wired_wdata),
    .hold_i       (rnd_hold),
    .random_o     (rnd)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    pmiss_d  = pmiss_q;
    pidx_d   = pidx_q;
    entry_d  = entry_q;
    op_done  = 1'b0;
    tlbwi    = 1'b0;
    tlbwr    = 1'b0;
    index_we = 1'b0;
    conf_we  = 1'b0;
    rnd_hold = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = tlb_op_t'(op_type);
          // Random is sampled before any same-cycle Wired reload lands.
          idx_d = (op_type == OP_TLBWR) ? rnd : cp0_index_in;
          unique case (tlb_op_t'(op_type))
            OP_TLBP: state_d = ST_PROBE_WAIT;
            OP_TLBR: state_d = ST_READ_WAIT;
            default: state_d = ST_WRITE;
          endcase
        end
      end
      ST_PROBE_WAIT: begin
        if (flush) state_d = ST_IDLE;
        else begin
          pmiss_d = probe_miss;
          pidx_d  = probe_index;
          state_d = ST_DRAIN;
        end
      end
      ST_READ_WAIT: begin
        if (flush) state_d = ST_IDLE;
        else begin
          entry_d = entry_in;
          state_d = ST_DRAIN;
        end
      end
      ST_WRITE: begin
        rnd_hold = (op_q == OP_TLBWR);
        if (flush) state_d = ST_IDLE;
        else begin
          tlbwi   = (op_q == OP_TLBWI);
          tlbwr   = (op_q == OP_TLBWR);
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        op_done  = 1'b1;
        index_we = (op_q == OP_TLBP);
        conf_we  = (op_q == OP_TLBR);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A reset cycle drops whatever would have committed.
    if (rst) begin
      op_done  = 1'b0;
      tlbwi    = 1'b0;
      tlbwr    = 1'b0;
      index_we = 1'b0;
      conf_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_TLBP;
      idx_q   <= '0;
      pmiss_q <= 1'b0;
      pidx_q  <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      pmiss_q <= pmiss_d;
      pidx_q  <= pidx_d;
      entry_q <= entry_d;
    end
  end

  assign tlb_index   = idx_q;
  // TLBWR presents its latched slot on Random while the write is in flight.
  assign random      = (state_q == ST_WRITE && op_q == OP_TLBWR) ? idx_q : rnd;
  assign index_wdata = {pmiss_q, {(INDEX_P_BIT - INDEX_W){1'b0}},
                        pmiss_q ? {INDEX_W{1'b0}} : pidx_q};
  assign conf_wdata  = entry_q;

`ifdef TLB_OP_PERF_CNT_EN
  logic [31:0] pm_cnt_q, tw_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_cnt_q <= '0;
      tw_cnt_q <= '0;
    end else begin
      if (op_done && op_q == OP_TLBP && pmiss_q) pm_cnt_q <= pm_cnt_q + 32'd1;
      if (op_done && (op_q == OP_TLBWI || op_q == OP_TLBWR))
        tw_cnt_q <= tw_cnt_q + 32'd1;
    end
  end

  assign perf_probe_miss_cnt = pm_cnt_q;
  assign perf_tlbw_cnt       = tw_cnt_q;
`endif

endmodule
